ex_stage_muldiv: RTL and testbench

Parametrised execute stage: RV32I ALU/branch path plus an RV32M multiply/divide path behind a valid/ready pipeline handshake. Sits between ID and MEM. Single-cycle ops complete in one cycle; M-extension ops run on an iterative multi-cycle unit that back-pressures ID. Results are registered and held until MEM accepts them; a flush input kills in-flight work.

---
 rtl/ex_pkg.sv | 57 +++++
 rtl/muldiv_iter.sv | 150 +++++++++++++++
 rtl/ex_stage_muldiv.sv | 146 ++++++++++++++
 tb/tb_ex_stage_muldiv.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: RV32I/M opcode and funct fields,
// multi-cycle unit state codes, and the decoded M-op descriptor.
package ex_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_f3_e;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
    logic is_div;
    logic is_rem;
    logic want_high;
  } mop_t;

  function automatic mop_t decode_mop(input logic [2:0] f3);
    mop_t m;
    m.is_div    = f3[2];
    m.is_rem    = f3[2] & f3[1];
    m.want_high = !f3[2] && (f3[1:0] != 2'b00);
    m.a_signed  = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    m.b_signed  = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    return m;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on magnitudes, with sign fix-up on the way out.
//
//   state  | meaning
//   IDLE   | waiting for start; special-case divides are answered combinationally
//   BUSY   | retiring BITS_PER_CYCLE bits per cycle, counter 0..ITERS-1
//   DONE   | result valid; held until the parent takes it
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic            take,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [4:0]      rd,
  output logic            idle,
  output logic            done,
  output logic            special,
  output logic [XLEN-1:0] special_result,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] b_hold,
  output logic [4:0]      rd_hold
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] hi, lo, opb;
  logic [XLEN-1:0] hi_nx, lo_nx;
  logic [XLEN:0]   sum;
  logic            a_neg, b_neg;
  mop_t            op, in_op;

  logic            div_zero, div_ovf, a_neg_in, b_neg_in;
  logic [XLEN-1:0] mag_a, mag_b;

  assign in_op    = decode_mop(funct3);
  assign div_zero = in_op.is_div && (data2 == '0);
  assign div_ovf  = in_op.is_div && in_op.a_signed && (data1 == INT_MIN) && (data2 == '1);
  assign special  = div_zero || div_ovf;
  assign special_result = div_zero ? (in_op.is_rem ? data1 : '1)
                                   : (in_op.is_rem ? '0 : data1);

  assign a_neg_in = in_op.a_signed && data1[XLEN-1];
  assign b_neg_in = in_op.b_signed && data2[XLEN-1];
  assign mag_a    = a_neg_in ? -data1 : data1;
  assign mag_b    = b_neg_in ? -data2 : data2;

  // Multiply and divide share {hi, lo}: product for MUL*, remainder:quotient for DIV/REM.
  always_comb begin
    hi_nx = hi;
    lo_nx = lo;
    sum   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op.is_div) begin
        sum   = {hi_nx, lo_nx[XLEN-1]};
        lo_nx = {lo_nx[XLEN-2:0], 1'b0};
        if (sum >= {1'b0, opb}) begin
          sum      = sum - {1'b0, opb};
          lo_nx[0] = 1'b1;
        end
        hi_nx = sum[XLEN-1:0];
      end else begin
        sum   = {1'b0, hi_nx} + (lo_nx[0] ? {1'b0, opb} : '0);
        lo_nx = {sum[0], lo_nx[XLEN-1:1]};
        hi_nx = sum[XLEN:1];
      end
    end
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign prod     = {hi, lo};
  assign prod_fix = (a_neg ^ b_neg) ? -prod : prod;
  assign quo_fix  = (a_neg ^ b_neg) ? -lo : lo;
  assign rem_fix  = a_neg ? -hi : hi;

  always_comb begin
    result = '0;
    if (op.is_div)
      result = op.is_rem ? rem_fix : quo_fix;
    else
      result = op.want_high ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  assign idle = (state == S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      opb     <= '0;
      op      <= '0;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
      b_hold  <= '0;
      rd_hold <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !special) begin
            hi      <= '0;
            lo      <= mag_a;
            opb     <= mag_b;
            op      <= in_op;
            a_neg   <= a_neg_in;
            b_neg   <= b_neg_in;
            b_hold  <= data2;
            rd_hold <= rd;
            cnt     <= '0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          hi <= hi_nx;
          lo <= lo_nx;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (take) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_muldiv.sv
// Execute stage: single-cycle RV32I ALU/branch path plus iterative RV32M unit,
// with a registered valid/ready output toward MEM.
module ex_stage_muldiv
  import ex_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] pc_from_id,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            jump_or_branch,
  output logic [XLEN-1:0] b,
  output logic [XLEN-1:0] c,
  output logic [4:0]      reg_wr_addr
);

  localparam int SHW = $clog2(XLEN);

  logic            is_m, accept, out_free, alt;
  logic            mdu_idle, mdu_done, mdu_special;
  logic [XLEN-1:0] mdu_special_result, mdu_result, mdu_b;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] op_a, op_b, alu_res, i_res;
  logic [SHW-1:0]  shamt;
  logic            br_taken, i_jb;

  assign is_m     = (opcode == OP_REG) && (funct7 == FUNCT7_MULDIV);
  assign out_free = !out_valid || out_ready;
  assign in_ready = mdu_idle && out_free && !flush;
  assign accept   = in_valid && in_ready;

  muldiv_iter #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_muldiv (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .start          (accept && is_m),
    .take           (mdu_done && out_free),
    .funct3         (funct3),
    .data1          (data1),
    .data2          (data2),
    .rd             (rd),
    .idle           (mdu_idle),
    .done           (mdu_done),
    .special        (mdu_special),
    .special_result (mdu_special_result),
    .result         (mdu_result),
    .b_hold         (mdu_b),
    .rd_hold        (mdu_rd)
  );

  assign op_a  = (opcode == OP_AUIPC) ? pc_from_id : data1;
  assign op_b  = (opcode == OP_REG) ? data2 : imm;
  assign shamt = op_b[SHW-1:0];
  // funct7[5] selects SUB only for register ops; for shifts it selects SRA in both forms.
  assign alt   = funct7[5] && ((opcode == OP_REG) || (funct3 == 3'b101));

  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000: alu_res = alt ? (op_a - op_b) : (op_a + op_b);
      3'b001: alu_res = op_a << shamt;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      3'b100: alu_res = op_a ^ op_b;
      3'b101: alu_res = alt ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
      3'b110: alu_res = op_a | op_b;
      3'b111: alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      BR_EQ:   br_taken = (data1 == data2);
      BR_NE:   br_taken = (data1 != data2);
      BR_LT:   br_taken = ($signed(data1) < $signed(data2));
      BR_GE:   br_taken = ($signed(data1) >= $signed(data2));
      BR_LTU:  br_taken = (data1 < data2);
      BR_GEU:  br_taken = (data1 >= data2);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    i_res = alu_res;
    i_jb  = 1'b0;
    case (opcode)
      OP_LUI:   i_res = imm;
      OP_AUIPC: i_res = op_a + imm;
      OP_JAL, OP_JALR: begin
        i_res = pc_from_id + XLEN'(4);
        i_jb  = 1'b1;
      end
      OP_BRANCH: begin
        i_res = pc_from_id + imm;
        i_jb  = br_taken;
      end
      OP_LOAD, OP_STORE: i_res = data1 + imm;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      jump_or_branch <= 1'b0;
      b              <= '0;
      c              <= '0;
      reg_wr_addr    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept && (!is_m || mdu_special)) begin
      out_valid      <= 1'b1;
      jump_or_branch <= is_m ? 1'b0 : i_jb;
      b              <= data2;
      c              <= is_m ? mdu_special_result : i_res;
      reg_wr_addr    <= rd;
    end else if (mdu_done && out_free) begin
      out_valid      <= 1'b1;
      jump_or_branch <= 1'b0;
      b              <= mdu_b;
      c              <= mdu_result;
      reg_wr_addr    <= mdu_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Directed and randomized checks of ex_stage_muldiv against an arithmetic
// reference model (64-bit products, native divide with the RV32M corner rules).
module tb_ex_stage_muldiv;

  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_M       = 7'b0000001;
  localparam logic [31:0] MIN32     = 32'h8000_0000;
  localparam int M_LAT = 34;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, jump_or_branch;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] pc_from_id, data1, data2, imm, b, c;
  logic [4:0]  rd, reg_wr_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_stage_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .pc_from_id     (pc_from_id),
    .data1          (data1),
    .data2          (data2),
    .imm            (imm),
    .rd             (rd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .jump_or_branch (jump_or_branch),
    .b              (b),
    .c              (c),
    .reg_wr_addr    (reg_wr_addr)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] bb);
    longint     sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(bb));
    case (f3)
      3'd0: begin p = 64'(a) * 64'(bb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'b0, bb})); return p[63:32]; end
      3'd3: begin p = 64'(a) * 64'(bb); return p[63:32]; end
      3'd4: begin
        if (bb == 0) return 32'hFFFF_FFFF;
        if (a == MIN32 && bb == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (bb == 0) return 32'hFFFF_FFFF;
        return a / bb;
      end
      3'd6: begin
        if (bb == 0) return a;
        if (a == MIN32 && bb == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (bb == 0) return a;
        return a % bb;
      end
    endcase
  endfunction

  function automatic bit m_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] bb);
    return f3[2] && ((bb == 0) || (!f3[0] && a == MIN32 && bb == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] r_model(input logic [2:0] f3, input bit alt, input logic [31:0] a, input logic [31:0] bb);
    case (f3)
      3'd0: return alt ? a - bb : a + bb;
      3'd1: return a << bb[4:0];
      3'd2: return ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
      3'd3: return (a < bb) ? 32'd1 : 32'd0;
      3'd4: return a ^ bb;
      3'd5: return alt ? 32'($signed(a) >>> bb[4:0]) : a >> bb[4:0];
      3'd6: return a | bb;
      default: return a & bb;
    endcase
  endfunction

  // Drive an op at a negedge, wait (bounded) for in_ready, return at the negedge after the accept edge.
  task automatic drive_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] bb, input logic [31:0] im,
                          input logic [4:0] r);
    int n;
    opcode = op; funct3 = f3; funct7 = f7; data1 = a; data2 = bb; imm = im; rd = r;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("accept_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp_c, input logic [31:0] exp_b,
                             input logic [4:0] exp_rd, input bit exp_jb, input int exp_lat,
                             input bit chk_busy);
    int lat, busy_bad;
    lat = 1;
    busy_bad = 0;
    while (!out_valid && lat < 100) begin
      if (chk_busy && in_ready) busy_bad++;
      @(negedge clk);
      lat++;
    end
    check({name, " valid"}, out_valid, 1'b1);
    check({name, " c"}, c, exp_c);
    check({name, " b"}, b, exp_b);
    check({name, " rd"}, reg_wr_addr, exp_rd);
    check({name, " jb"}, jump_or_branch, exp_jb);
    check({name, " latency"}, lat, exp_lat);
    if (chk_busy) check({name, " busy_in_ready"}, busy_bad, 0);
  endtask

  task automatic m_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] bb, input logic [4:0] r);
    bit sp;
    sp = m_special(f3, a, bb);
    drive_op(OPC_REG, f3, F7_M, a, bb, 32'd0, r);
    wait_result(name, m_model(f3, a, bb), bb, r, 1'b0, sp ? 1 : M_LAT, !sp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_q[8];
    logic [31:0] ra, rb, held_c;
    logic [2:0]  f3;
    logic [4:0]  rr;
    bit          alt;
    int          bad, seen;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    pc_from_id = 32'h0000_1000; data1 = '0; data2 = '0; imm = '0; rd = '0;
    repeat (2) @(negedge clk);
    check("reset out_valid", out_valid, 1'b0);
    check("reset c", c, 32'd0);
    check("reset b", b, 32'd0);
    check("reset rd", reg_wr_addr, 5'd0);
    check("reset jb", jump_or_branch, 1'b0);
    rst = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1'b1);
    @(negedge clk);

    drive_op(OPC_REG, 3'b000, 7'b0000000, 32'd7, 32'd5, 32'd0, 5'd5);
    wait_result("add", 32'd12, 32'd5, 5'd5, 1'b0, 1, 1'b0);

    // Back-to-back register ops, one accepted and one retired per cycle.
    in_valid = 1'b1;
    opcode = OPC_REG;
    for (int i = 0; i < 8; i++) begin
      f3  = 3'($urandom_range(0, 7));
      alt = ((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) == 1);
      ra  = $urandom; rb = $urandom; rr = 5'($urandom_range(1, 31));
      funct3 = f3; funct7 = alt ? 7'b0100000 : 7'b0000000;
      data1 = ra; data2 = rb; rd = rr;
      exp_q[i] = r_model(f3, alt, ra, rb);
      #1;
      check("b2b in_ready", in_ready, 1'b1);
      @(negedge clk);
      check("b2b valid", out_valid, 1'b1);
      check("b2b c", c, exp_q[i]);
      check("b2b rd", reg_wr_addr, rr);
    end
    in_valid = 1'b0;

    drive_op(OPC_BRANCH, 3'b000, 7'd0, 32'd42, 32'd42, 32'h40, 5'd0);
    wait_result("beq taken", 32'h0000_1040, 32'd42, 5'd0, 1'b1, 1, 1'b0);
    drive_op(OPC_BRANCH, 3'b001, 7'd0, 32'd42, 32'd42, 32'h40, 5'd0);
    wait_result("bne not taken", 32'h0000_1040, 32'd42, 5'd0, 1'b0, 1, 1'b0);

    m_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6);
    check("mulh const", c, 32'h4000_0000);
    m_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7);
    check("div const", c, 32'hFFFF_FFFD);
    m_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8);
    check("rem const", c, 32'hFFFF_FFFF);
    m_op("divu by zero", 3'd5, 32'd1234, 32'd0, 5'd9);
    check("divu0 const", c, 32'hFFFF_FFFF);
    m_op("div overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    check("div ovf const", c, 32'h8000_0000);
    m_op("rem overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    check("rem ovf const", c, 32'd0);
    m_op("rem by zero", 3'd6, 32'hDEAD_BEEF, 32'd0, 5'd12);

    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = MIN32; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      m_op("rand m", f3, ra, rb, 5'($urandom_range(1, 31)));
    end

    // Backpressure: hold out_ready low for 5 cycles once the M result is up.
    drive_op(OPC_REG, 3'd0, F7_M, 32'd1000, 32'd3000, 32'd0, 5'd13);
    out_ready = 1'b0;
    wait_result("mul bp", 32'd3_000_000, 32'd3000, 5'd13, 1'b0, M_LAT, 1'b1);
    held_c = c;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || c !== held_c || in_ready || reg_wr_addr !== 5'd13) bad++;
    end
    check("bp hold", bad, 0);
    out_ready = 1'b1;
    #1;
    check("bp in_ready rises", in_ready, 1'b1);
    @(negedge clk);
    check("bp retired", out_valid, 1'b0);

    // Flush during BUSY cycle 10.
    drive_op(OPC_REG, 3'd4, F7_M, 32'd1000, 32'd7, 32'd0, 5'd14);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush cycle in_ready", in_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush out_valid", out_valid, 1'b0);
    check("flush idle", in_ready, 1'b1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush no stale", seen, 0);
    drive_op(OPC_REG, 3'b000, 7'd0, 32'd20, 32'd22, 32'd0, 5'd15);
    wait_result("add after flush", 32'd42, 32'd22, 5'd15, 1'b0, 1, 1'b0);

    // Reset during BUSY cycle 10.
    drive_op(OPC_REG, 3'd0, F7_M, 32'd123, 32'd456, 32'd0, 5'd16);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst out_valid", out_valid, 1'b0);
    check("rst c", c, 32'd0);
    check("rst idle", in_ready, 1'b1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst no stale", seen, 0);
    drive_op(OPC_REG, 3'b000, 7'b0100000, 32'd50, 32'd8, 32'd0, 5'd17);
    wait_result("sub after rst", 32'd42, 32'd8, 5'd17, 1'b0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
